// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video geometry defaults, unpack phase type and byte-lane offsets
package video_pkg;

  localparam int DEF_X_SIZE = 960;
  localparam int DEF_Y_SIZE = 720;

  localparam int LANE0 = 0;
  localparam int LANE1 = 8;
  localparam int LANE2 = 16;
  localparam int LANE3 = 24;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} ph_t;

  function automatic ph_t next_phase(input ph_t p);
    case (p)
      PH0:     return PH1;
      PH1:     return PH2;
      PH2:     return PH3;
      default: return PH0;
    endcase
  endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// rtl/frame_pos_counter.sv - x/y position of the next pixel to load and completed-frame count
module frame_pos_counter #(
  parameter int X_SIZE      = 960,
  parameter int Y_SIZE      = 720,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  input  logic                   clr,
  output logic [10:0]            x,
  output logic [10:0]            y,
  output logic                   sof,
  output logic                   eol,
  output logic                   last_of_frame,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [10:0] X_LAST = 11'(X_SIZE - 1);
  localparam logic [10:0] Y_LAST = 11'(Y_SIZE - 1);

  logic [10:0] x_q, y_q;
  logic [10:0] base_x, base_y;

  // clr restarts the position at (0,0) for the pixel being loaded in the same cycle
  assign base_x = clr ? '0 : x_q;
  assign base_y = clr ? '0 : y_q;

  assign x             = x_q;
  assign y             = y_q;
  assign sof           = (x_q == '0) && (y_q == '0);
  assign eol           = (x_q == X_LAST);
  assign last_of_frame = eol && (y_q == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_count <= '0;
    end else if (inc) begin
      if (base_x == X_LAST) begin
        x_q <= '0;
        if (base_y == Y_LAST) begin
          y_q         <= '0;
          frame_count <= frame_count + 1'b1;
        end else begin
          y_q <= base_y + 11'd1;
        end
      end else begin
        x_q <= base_x + 11'd1;
        y_q <= base_y;
      end
    end else if (clr) begin
      x_q <= '0;
      y_q <= '0;
    end
  end

endmodule

// File: rtl/stream_unpacker.sv
// rtl/stream_unpacker.sv - unpacks 3-word/4-pixel 24-bit video groups into tagged pixels
module stream_unpacker
  import video_pkg::*;
#(
  parameter int X_SIZE      = DEF_X_SIZE,
  parameter int Y_SIZE      = DEF_Y_SIZE,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            in_stream_tdata,
  input  logic [3:0]             in_stream_tkeep,
  input  logic                   in_stream_tlast,
  input  logic                   in_stream_tuser,
  input  logic                   in_stream_tvalid,
  output logic                   in_stream_tready,
  output logic [7:0]             pix_r,
  output logic [7:0]             pix_g,
  output logic [7:0]             pix_b,
  output logic [10:0]            pix_x,
  output logic [10:0]            pix_y,
  output logic                   pix_sof,
  output logic                   pix_eol,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   sof_err,
  output logic                   eol_err,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [10:0] X_EOL_WORD = 11'(X_SIZE - 2);

  ph_t         phase, eff_phase;
  logic [23:0] res, res_next, pix_next;
  logic        locked;
  logic [10:0] cnt_x, cnt_y;
  logic        cnt_sof, cnt_eol, cnt_last;
  logic        out_free, accept, take_word, resync, emit_ph3, load;
  logic        exp_tlast, sof_err_next, eol_err_next;
  logic        unused_ok;

  assign unused_ok = &{1'b0, in_stream_tkeep, cnt_last};

  assign out_free         = !pix_valid | pix_ready;
  assign in_stream_tready = !reset & (!locked | (out_free & (phase != PH3)));
  assign accept           = in_stream_tvalid & in_stream_tready;
  // Before lock only a tuser word is kept; everything else is dropped on the floor
  assign take_word        = accept & (locked | in_stream_tuser);
  assign resync           = take_word & in_stream_tuser & (!locked | (phase != PH0) | !cnt_sof);
  assign emit_ph3         = locked & (phase == PH3) & out_free;
  assign load             = take_word | emit_ph3;
  assign eff_phase        = resync ? PH0 : phase;
  assign exp_tlast        = !resync & (phase == PH2) & (cnt_x == X_EOL_WORD);

  assign sof_err_next = take_word & locked &
                        ((in_stream_tuser & ((phase != PH0) | !cnt_sof)) |
                         (!in_stream_tuser & (phase == PH0) & cnt_sof));
  assign eol_err_next = take_word & (in_stream_tlast != exp_tlast);

  always_comb begin
    pix_next = res;
    res_next = res;
    case (eff_phase)
      PH0: begin
        pix_next = in_stream_tdata[LANE0 +: 24];
        res_next = {16'h0, in_stream_tdata[LANE3 +: 8]};
      end
      PH1: begin
        pix_next = {in_stream_tdata[LANE0 +: 16], res[7:0]};
        res_next = {8'h0, in_stream_tdata[LANE2 +: 16]};
      end
      PH2: begin
        pix_next = {in_stream_tdata[LANE0 +: 8], res[15:0]};
        res_next = in_stream_tdata[LANE1 +: 24];
      end
      default: begin
        pix_next = res;
        res_next = res;
      end
    endcase
  end

  frame_pos_counter #(
    .X_SIZE      (X_SIZE),
    .Y_SIZE      (Y_SIZE),
    .FRAME_CNT_W (FRAME_CNT_W)
  ) u_pos (
    .clk           (clk),
    .reset         (reset),
    .inc           (load),
    .clr           (resync),
    .x             (cnt_x),
    .y             (cnt_y),
    .sof           (cnt_sof),
    .eol           (cnt_eol),
    .last_of_frame (cnt_last),
    .frame_count   (frame_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= PH0;
      res       <= '0;
      locked    <= 1'b0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_valid <= 1'b0;
      sof_err   <= 1'b0;
      eol_err   <= 1'b0;
    end else begin
      sof_err <= sof_err_next;
      eol_err <= eol_err_next;
      if (resync) locked <= 1'b1;
      if (load) begin
        phase                 <= next_phase(eff_phase);
        res                   <= res_next;
        {pix_r, pix_g, pix_b} <= pix_next;
        pix_x                 <= resync ? '0 : cnt_x;
        pix_y                 <= resync ? '0 : cnt_y;
        pix_sof               <= resync | cnt_sof;
        pix_eol               <= !resync & cnt_eol;
        pix_valid             <= 1'b1;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule
